// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester arbiter/sequencer that time-shares one ALU.
//
// Requester 0 is the core execute stage; requester 1 is the address/branch-offset
// unit. The winner's operands are latched and presented to the ALU for one
// cycle (EXEC). The ALU's combinational result and flags are then captured and
// returned with a done pulse (DONE). During DONE the next request may be granted,
// giving one operation every two cycles.
//
// Ports:
//   CLK, reset          clock (rising edge), asynchronous active-low reset
//   req0/opa0/opb0/op0  requester 0 request level and operands/opcode
//   req1/opa1/opb1/op1  requester 1 request level and operands/opcode
//   gnt0/gnt1           one-cycle pulse: that requester's operands were latched
//   done0/done1         one-cycle pulse: res/flags valid for that requester
//   res/res_zero/res_ovfl captured ALU result and flags (shared)
//   busy                high while in EXEC or DONE
//   alu_a/alu_b/alu_op  registered operands/opcode to the ALU
//   alu_src             ALU A-mux select, tied to 0 (alu_a path)
//   alu_r/alu_zero/alu_ovfl combinational ALU result and flags

module alu_share_arb #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned OPW        = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  input  logic [OPW-1:0]   op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_zero,
  output logic             res_ovfl,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_src,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovfl
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_zero_q, res_zero_d;
  logic             res_ovfl_q, res_ovfl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  // Also identifies the owner of the in-flight operation.
  logic             last_q, last_d;

  logic             rr_mode;
  logic             any_req;
  logic             win1;
  logic             grant;

  assign rr_mode = (FIXED_PRIO == 0);
  assign any_req = req0 | req1;
  // Requester 1 wins when alone, or on a round-robin tie when 0 went last.
  assign win1    = req1 & (~req0 | (rr_mode & ~last_q));

  always_comb begin
    state_d    = state_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    res_d      = res_q;
    res_zero_d = res_zero_q;
    res_ovfl_d = res_ovfl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    last_d     = last_q;
    grant      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        // Requests are ignored here; the ALU sees the latched operands.
        res_d      = alu_r;
        res_zero_d = alu_zero;
        res_ovfl_d = alu_ovfl;
        done0_d    = ~last_q;
        done1_d    = last_q;
        state_d    = StDone;
      end
      StDone: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = StExec;
        end else begin
          alu_a_d  = '0;
          alu_b_d  = '0;
          alu_op_d = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (grant) begin
      last_d   = win1;
      gnt0_d   = ~win1;
      gnt1_d   = win1;
      alu_a_d  = win1 ? opa1 : opa0;
      alu_b_d  = win1 ? opb1 : opb0;
      alu_op_d = win1 ? op1  : op0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_ovfl_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      // First tie after reset goes to requester 0.
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
      res_ovfl_q <= res_ovfl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      last_q     <= last_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res      = res_q;
  assign res_zero = res_zero_q;
  assign res_ovfl = res_ovfl_q;
  assign busy     = (state_q != StIdle);
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign alu_src  = 1'b0;

endmodule
